// File: rtl/carry_select_subtractor_pipe.sv
// rtl/carry_select_subtractor_pipe.sv - two-stage pipelined carry-select subtractor
//
// Computes diff = (A - B - bin) mod 2^WIDTH as A + ~B + ~bin.
// Stage 1 resolves the low half and registers its carry.
// Stage 2 resolves the high half from that registered carry.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (A, B, bin)
//   out_valid/out_ready   result handshake (diff, bout, ovf)
//   bout                  1 when A < B + bin (unsigned)
//   ovf                   two's-complement overflow of the signed subtraction
module carry_select_subtractor_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int NBLK = HALF / BLOCK;

  // Bit-serial ripple adder over one block; returns {carry, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] a,
                                            input logic [BLOCK-1:0] b,
                                            input logic             cin);
    logic [BLOCK-1:0] s;
    logic             c;
    c = cin;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // Carry-select half adder: the bottom block ripples on the real carry.
  // Each higher block precomputes both carry-in cases and muxes on the
  // carry arriving from below, so the chain is one ripple block plus muxes.
  function automatic logic [HALF:0] cs_half(input logic [HALF-1:0] a,
                                            input logic [HALF-1:0] b,
                                            input logic            cin);
    logic [HALF-1:0]  s;
    logic             c;
    logic [BLOCK:0]   r0;
    logic [BLOCK:0]   r1;
    s  = '0;
    r0 = ripple(a[BLOCK-1:0], b[BLOCK-1:0], cin);
    s[BLOCK-1:0] = r0[BLOCK-1:0];
    c  = r0[BLOCK];
    for (int k = 1; k < NBLK; k++) begin
      r0 = ripple(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b0);
      r1 = ripple(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b1);
      s[k*BLOCK +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      c = c ? r1[BLOCK] : r0[BLOCK];
    end
    return {c, s};
  endfunction

  // Stage 1 registers
  logic            s1_valid;
  logic [HALF-1:0] s1_dlo;
  logic            s1_c;
  logic [HALF-1:0] s1_ahi;
  logic [HALF-1:0] s1_bhi_n;
  logic            s1_amsb;
  logic            s1_bmsb;

  // Stage 2 registers
  logic            s2_valid;

  logic            s2_adv;
  logic            s1_adv;
  logic [HALF:0]   lo_sum;
  logic [HALF:0]   hi_sum;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Subtraction as addition: invert B and feed ~bin as the carry-in.
  assign lo_sum = cs_half(A[HALF-1:0], ~B[HALF-1:0], ~bin);
  assign hi_sum = cs_half(s1_ahi, s1_bhi_n, s1_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_c     <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi_n <= '0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (s1_adv) begin
      // A bubble (in_valid = 0) still loads data; it is never presented.
      s1_valid <= in_valid;
      s1_dlo   <= lo_sum[HALF-1:0];
      s1_c     <= lo_sum[HALF];
      s1_ahi   <= A[WIDTH-1:HALF];
      s1_bhi_n <= ~B[WIDTH-1:HALF];
      s1_amsb  <= A[WIDTH-1];
      s1_bmsb  <= B[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      diff     <= {hi_sum[HALF-1:0], s1_dlo};
      bout     <= ~hi_sum[HALF];
      ovf      <= (s1_amsb != s1_bmsb) && (hi_sum[HALF-1] != s1_amsb);
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// tb/tb_carry_select_subtractor_pipe.sv - directed and streaming checks of carry_select_subtractor_pipe
module tb_carry_select_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        qbin[$];

  carry_select_subtractor_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result packed as {bout, ovf, diff}.
  function automatic logic [31:0] res_now();
    return {14'b0, bout, ovf, diff};
  endfunction

  function automatic logic [31:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                        input logic xbin);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, xa} - {1'b0, xb} - {16'b0, xbin};
    ov = (xa[15] != xb[15]) && (t[15] != xa[15]);
    return {14'b0, t[16], ov, t[15:0]};
  endfunction

  // Scoreboard: expected results enter on input transfer, leave on output transfer.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          check("stream", res_now(), exp_q[0]);
          void'(exp_q.pop_front());
        end
        xfer_cyc.push_back(ncyc);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // One operation through an empty pipeline, with hand-computed result.
  task automatic single(input logic [15:0] xa, input logic [15:0] xb, input logic xbin,
                        input logic [31:0] exp);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("acc_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("result", res_now(), exp);
    @(posedge clk); #1;
  endtask

  // Streams qa/qb/qbin back to back; optionally stalls out_ready for
  // stall_len cycles starting when the first result appears.
  task automatic run_stream(input int n, input int stall_len);
    int          i;
    int          base;
    int          left;
    bit          stalled;
    logic        acc;
    logic [31:0] frz;
    base = xfer_cyc.size();
    i = 0; left = 0; stalled = 0; frz = '0;
    a = qa[0]; b = qb[0]; bin = qbin[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3 * n + 50; c++) begin
      if (i >= n && xfer_cyc.size() >= base + n) break;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        if (i < n) begin
          a = qa[i]; b = qb[i]; bin = qbin[i];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (left > 0) begin
        check("frozen_data", res_now(), frz);
        check("frozen_valid", 32'(out_valid), 32'd1);
        check("stall_ready", 32'(in_ready), 32'd0);
        left--;
        if (left == 0) out_ready = 1'b1;
      end else if (!stalled && stall_len > 0 && out_valid) begin
        stalled = 1;
        out_ready = 1'b0;
        frz = res_now();
        left = stall_len;
        #1;
        check("stall_ready_drop", 32'(in_ready), 32'd0);
      end
    end
    check("stream_count", 32'(xfer_cyc.size() - base), 32'(n));
    if (xfer_cyc.size() >= base + n)
      check("stream_gap", 32'(xfer_cyc[base+n-1] - xfer_cyc[base]), 32'(n - 1));
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    single(16'h0005, 16'h0003, 1'b0, 32'h0000_0002);
    single(16'h0003, 16'h0005, 1'b0, 32'h0002_FFFE);
    single(16'h0000, 16'h0000, 1'b1, 32'h0002_FFFF);
    single(16'h8000, 16'h0001, 1'b0, 32'h0001_7FFF);
    single(16'h00FF, 16'h00FF, 1'b1, 32'h0002_FFFF);
    single(16'h7FFF, 16'hFFFF, 1'b0, 32'h0003_8000);

    for (int x = 0; x < 2; x++)
      for (int ia = 32; ia < 64; ia++)
        for (int ib = 16; ib < 32; ib++) begin
          qa.push_back(16'(ia)); qb.push_back(16'(ib)); qbin.push_back(x[0]);
        end
    run_stream(qa.size(), 0);

    qa.delete(); qb.delete(); qbin.delete();
    for (int k = 0; k < 5; k++) begin
      qa.push_back(16'h1000 * 16'(k) + 16'h0123);
      qb.push_back(16'h0F0F + 16'(k));
      qbin.push_back(k[0]);
    end
    run_stream(5, 4);

    @(posedge clk); #1;
    out_ready = 1'b0; a = 16'h1111; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    base = xfer_cyc.size();
    single(16'h1234, 16'h0234, 1'b0, 32'h0000_1000);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_count", 32'(xfer_cyc.size() - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
